// File: rtl/dadda_divider_pkg.sv
// Shared types and default widths for the restoring divider.
package dadda_pkg;

  localparam int unsigned DEF_N_DIVIDEND = 8;
  localparam int unsigned DEF_N_DIVISOR  = 4;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract if it fits.
module div_step
  import dadda_pkg::*;
#(
  parameter int unsigned N_DIVISOR = DEF_N_DIVISOR
) (
  input  logic [N_DIVISOR-1:0] rem,
  input  logic                 dividend_bit,
  input  logic [N_DIVISOR-1:0] divisor,
  output logic [N_DIVISOR-1:0] new_rem,
  output logic                 quotient_bit
);

  logic [N_DIVISOR:0] partial;

  always_comb begin
    partial      = {rem, dividend_bit};
    quotient_bit = (partial >= {1'b0, divisor});
    // rem < divisor on entry, so the difference always fits in N_DIVISOR bits
    new_rem      = quotient_bit ? N_DIVISOR'(partial - {1'b0, divisor})
                                : partial[N_DIVISOR-1:0];
  end

endmodule

// File: rtl/dadda_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
module dadda_divider
  import dadda_pkg::*;
#(
  parameter int unsigned N_DIVIDEND = DEF_N_DIVIDEND,
  parameter int unsigned N_DIVISOR  = DEF_N_DIVISOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_DIVIDEND-1:0] dividend,
  input  logic [N_DIVISOR-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [N_DIVIDEND-1:0] quotient,
  output logic [N_DIVISOR-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int unsigned CNT_W = $clog2(N_DIVIDEND + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_DIVIDEND - 1);

  state_t                  state;
  logic [N_DIVIDEND-1:0]   dvd_sh;
  logic [N_DIVISOR-1:0]    dvs_q;
  logic [CNT_W-1:0]        cnt;
  logic [N_DIVISOR-1:0]    rem_next;
  logic                    q_bit;

  div_step #(
    .N_DIVISOR(N_DIVISOR)
  ) u_step (
    .rem         (remainder),
    .dividend_bit(dvd_sh[N_DIVIDEND-1]),
    .divisor     (dvs_q),
    .new_rem     (rem_next),
    .quotient_bit(q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      cnt         <= '0;
      dvd_sh      <= '0;
      dvs_q       <= '0;
    end else begin
      case (state)
        CALC: begin
          remainder <= rem_next;
          quotient  <= {quotient[N_DIVIDEND-2:0], q_bit};
          dvd_sh    <= dvd_sh << 1;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done <= 1'b0;
          if (start) begin
            dvd_sh    <= dividend;
            dvs_q     <= divisor;
            cnt       <= '0;
            remainder <= '0;
            // A zero divisor skips CALC and reports the all-ones quotient at once
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
            end else begin
              state       <= CALC;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
              quotient    <= '0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dadda_divider.sv
// Self-checking bench for dadda_divider against plain integer / and % arithmetic.
module tb_dadda_divider;

  localparam int ND = 8;
  localparam int NS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [ND-1:0] dividend = '0;
  logic [NS-1:0] divisor = '0;
  logic          busy;
  logic          done;
  logic [ND-1:0] quotient;
  logic [NS-1:0] remainder;
  logic          div_by_zero;

  int total = 0;
  int bad = 0;

  dadda_divider #(
    .N_DIVIDEND(ND),
    .N_DIVISOR (NS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Edges after the acceptance edge until done is seen, and cycles with busy high.
  task automatic wait_done(output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input int a, input int b, output int lat, output int bcyc);
    @(negedge clk);
    start    = 1'b1;
    dividend = ND'(a);
    divisor  = NS'(b);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ND'($urandom);
    divisor  = NS'($urandom);
    wait_done(lat, bcyc);
  endtask

  task automatic test_reset;
    int lat, bcyc;
    @(negedge clk);
    rst = 1'b1; start = 1'b1; dividend = 8'd77; divisor = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b1; dividend = 8'd9; divisor = 4'd2;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL first_start_accept: got busy=%b expected 1", busy);
    end
    wait_done(lat, bcyc);
    total++;
    if (done !== 1'b1 || quotient !== 8'd4 || remainder !== 4'd1) begin
      bad++;
      $display("FAIL first_op_result: got done=%b q=%0d r=%0d expected done=1 q=4 r=1",
               done, quotient, remainder);
    end
  endtask

  task automatic test_basic;
    int lat, bcyc;
    run_op(200, 7, lat, bcyc);
    total++;
    if (lat != ND || bcyc != ND) begin
      bad++;
      $display("FAIL basic_timing: got latency=%0d busy_cycles=%0d expected %0d/%0d", lat, bcyc, ND, ND);
    end
    total++;
    if (quotient !== 8'd28 || remainder !== 4'd4 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL basic_200_7: got q=%0d r=%0d dbz=%b expected q=28 r=4 dbz=0",
               quotient, remainder, div_by_zero);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || quotient !== 8'd28 || remainder !== 4'd4) begin
      bad++;
      $display("FAIL done_pulse_hold: got done=%b q=%0d r=%0d expected done=0 q=28 r=4",
               done, quotient, remainder);
    end
  endtask

  task automatic test_corners;
    int lat, bcyc;
    int a[3] = '{255, 13, 0};
    int b[3] = '{15, 14, 5};
    for (int i = 0; i < 3; i++) begin
      run_op(a[i], b[i], lat, bcyc);
      total++;
      if (lat != ND || quotient !== ND'(a[i] / b[i]) || remainder !== NS'(a[i] % b[i])) begin
        bad++;
        $display("FAIL corner_%0d_%0d: got lat=%0d q=%0d r=%0d expected lat=%0d q=%0d r=%0d",
                 a[i], b[i], lat, quotient, remainder, ND, a[i] / b[i], a[i] % b[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bcyc;
    run_op(100, 0, lat, bcyc);
    total++;
    if (lat != 0 || bcyc != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dz_timing: got lat=%0d busy_cycles=%0d busy=%b expected 0/0/0", lat, bcyc, busy);
    end
    total++;
    if (div_by_zero !== 1'b1 || quotient !== 8'd255 || remainder !== 4'd0) begin
      bad++;
      $display("FAIL dz_result: got dbz=%b q=%0d r=%0d expected dbz=1 q=255 r=0",
               div_by_zero, quotient, remainder);
    end
  endtask

  task automatic test_ignore_start;
    int lat, bcyc, extra;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    start = 1'b1; dividend = 8'd50; divisor = 4'd3;
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'd1; divisor = 4'd1;
    wait_done(lat, bcyc);
    total++;
    if (lat + 4 != ND || quotient !== 8'd28 || remainder !== 4'd4) begin
      bad++;
      $display("FAIL ignore_start: got lat=%0d q=%0d r=%0d expected lat=%0d q=28 r=4",
               lat + 4, quotient, remainder, ND);
    end
    extra = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1) extra++; end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL ignore_no_second_done: got %0d extra done pulses expected 0", extra);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bcyc, seen;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({busy, done, div_by_zero, quotient, remainder} !== '0) begin
      bad++;
      $display("FAIL abort_outputs: got busy=%b done=%b dbz=%b q=%0d r=%0d expected all 0",
               busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin @(posedge clk); #1; if (done === 1'b1 || busy === 1'b1) seen++; end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d cycles with done/busy expected 0", seen);
    end
    run_op(9, 2, lat, bcyc);
    total++;
    if (lat != ND || quotient !== 8'd4 || remainder !== 4'd1) begin
      bad++;
      $display("FAIL abort_then_9_2: got lat=%0d q=%0d r=%0d expected lat=%0d q=4 r=1",
               lat, quotient, remainder, ND);
    end
  endtask

  task automatic test_back_to_back;
    int a[3] = '{200, 255, 13};
    int b[3] = '{7, 15, 14};
    int k, last;
    k = 0;
    last = 0;
    @(negedge clk);
    start = 1'b1; dividend = ND'(a[0]); divisor = NS'(b[0]);
    @(posedge clk); #1;
    for (int e = 1; e <= 40 && k < 3; e++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        total++;
        if (quotient !== ND'(a[k] / b[k]) || remainder !== NS'(a[k] % b[k])
            || (e - last) != (k == 0 ? ND : ND + 1)) begin
          bad++;
          $display("FAIL b2b_op%0d: got q=%0d r=%0d gap=%0d expected q=%0d r=%0d gap=%0d",
                   k, quotient, remainder, e - last, a[k] / b[k], a[k] % b[k],
                   (k == 0 ? ND : ND + 1));
        end
        last = e;
        k++;
        if (k < 3) begin
          dividend = ND'(a[k]);
          divisor  = NS'(b[k]);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    total++;
    if (k != 3) begin
      bad++;
      $display("FAIL b2b_count: got %0d results expected 3", k);
    end
  endtask

  task automatic test_random;
    int lat, bcyc, a, b, eq, er, ez, hold;
    for (int i = 0; i < 60; i++) begin
      a = int'($urandom_range(0, 255));
      b = (i % 10 == 0) ? 0 : int'($urandom_range(0, 15));
      run_op(a, b, lat, bcyc);
      eq = (b == 0) ? 255 : a / b;
      er = (b == 0) ? 0 : a % b;
      ez = (b == 0) ? 1 : 0;
      total++;
      if (done !== 1'b1 || quotient !== ND'(eq) || remainder !== NS'(er) || div_by_zero !== 1'(ez)) begin
        bad++;
        $display("FAIL rand_%0d_%0d: got done=%b q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%0d",
                 a, b, done, quotient, remainder, div_by_zero, eq, er, ez);
      end
      hold = int'($urandom_range(1, 4));
      repeat (hold) begin @(posedge clk); #1; end
      total++;
      if (quotient !== ND'(eq) || remainder !== NS'(er) || div_by_zero !== 1'(ez)) begin
        bad++;
        $display("FAIL rand_hold_%0d_%0d: got q=%0d r=%0d dbz=%b expected q=%0d r=%0d dbz=%0d",
                 a, b, quotient, remainder, div_by_zero, eq, er, ez);
      end
    end
  endtask

  task automatic test_sweep;
    int lat, bcyc, eq, er, el;
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, lat, bcyc);
        eq = (b == 0) ? 255 : a / b;
        er = (b == 0) ? 0 : a % b;
        el = (b == 0) ? 0 : ND;
        total++;
        if (lat != el || quotient !== ND'(eq) || remainder !== NS'(er)
            || div_by_zero !== (b == 0)) begin
          bad++;
          $display("FAIL sweep_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b expected lat=%0d q=%0d r=%0d",
                   a, b, lat, quotient, remainder, div_by_zero, el, eq, er);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
